// File: rtl/sbox_subbytes_seq_pkg.sv
// Shared definitions for the byte-serial SubBytes sequencer: widths,
// direction encodings, FSM state encoding and the GF(2^8) S-box datapath.
package sbox_subbytes_seq_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_BYTES   = 16;

    localparam logic SBOX_FWD = 1'b0;
    localparam logic SBOX_INV = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_sq(input logic [7:0] a);
        return gf_mul(a, a);
    endfunction

    // Tower inversion through the subfield norms: x^17 lies in GF(2^4),
    // its norm a^5 lies in GF(2^2) where b^-1 = b^2. Then
    // a^-1 = a^4 * (a^5)^2 and x^-1 = x^16 * (x^17)^-1. Zero maps to zero.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x16;
        logic [7:0] a;
        logic [7:0] a4;
        logic [7:0] n2;
        x16 = gf_sq(gf_sq(gf_sq(gf_sq(x))));
        a   = gf_mul(x16, x);
        a4  = gf_sq(gf_sq(a));
        n2  = gf_mul(a4, a);
        return gf_mul(x16, gf_mul(a4, gf_sq(n2)));
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] t;
        t = {v, v} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] aff_fwd(input logic [7:0] b);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] aff_inv(input logic [7:0] s);
        return rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05;
    endfunction

    function automatic logic [7:0] sbox_byte(input logic [7:0] b, input logic inv);
        if (inv == SBOX_INV) return gf_inv(aff_inv(b));
        return aff_fwd(gf_inv(b));
    endfunction

endpackage

// File: rtl/sbox_subbytes_seq_lane.sv
// One S-box lane: combinational forward/inverse S-box followed by PIPE
// register stages carrying data, group tag and valid.
module sbox_subbytes_seq_lane
    import sbox_subbytes_seq_pkg::*;
#(
    parameter int PIPE = 1,
    parameter int TW   = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_vld,
    input  logic [TW-1:0] in_tag,
    input  logic [7:0]    in_byte,
    input  logic          inv,
    output logic          out_vld,
    output logic [TW-1:0] out_tag,
    output logic [7:0]    out_byte
);

    logic [7:0]    sub;
    logic [7:0]    data_q [PIPE];
    logic [TW-1:0] tag_q  [PIPE];
    logic [PIPE-1:0] vld_q;

    // Substitute the incoming byte in the selected direction.
    always_comb begin
        sub = sbox_byte(in_byte, inv);
    end

    // Pipeline shift; valid bits clear on reset so stale data never retires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < PIPE; s++) begin
                data_q[s] <= '0;
                tag_q[s]  <= '0;
                vld_q[s]  <= 1'b0;
            end
        end else begin
            data_q[0] <= sub;
            tag_q[0]  <= in_tag;
            vld_q[0]  <= in_vld;
            for (int s = 1; s < PIPE; s++) begin
                data_q[s] <= data_q[s-1];
                tag_q[s]  <= tag_q[s-1];
                vld_q[s]  <= vld_q[s-1];
            end
        end
    end

    assign out_vld  = vld_q[PIPE-1];
    assign out_tag  = tag_q[PIPE-1];
    assign out_byte = data_q[PIPE-1];

endmodule

// File: rtl/sbox_subbytes_seq.sv
// Byte-serial SubBytes/InvSubBytes sequencer for one 128-bit AES state.
// LANES S-box lanes are time-multiplexed over the 16 state bytes.
//
//   state | meaning
//   IDLE  | waiting for a state, in_ready high
//   ISSUE | feeding one group of LANES bytes per cycle into the lanes
//   DRAIN | waiting for the remaining groups to leave the lane pipes
//   DONE  | result valid and frozen until out_ready
module sbox_subbytes_seq
    import sbox_subbytes_seq_pkg::*;
#(
    parameter int LANES = 4,
    parameter int PIPE  = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] state_in,
    input  logic                   inv_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] state_out,
    output logic                   busy
);

    localparam int ISSUES = AES_BYTES / LANES;
    localparam int TW     = (ISSUES > 1) ? $clog2(ISSUES) : 1;
    localparam int WW     = $clog2(ISSUES) + 1;
    localparam logic [TW-1:0] TLAST = TW'(ISSUES - 1);
    localparam logic [WW-1:0] WLAST = WW'(ISSUES);

    seq_state_t state_q, state_d;

    logic [AES_STATE_W-1:0] hold_q;
    logic [AES_STATE_W-1:0] result_q;
    logic                   inv_q;
    logic [TW-1:0]          icnt_q;
    logic [WW-1:0]          wcnt_q;
    logic [WW-1:0]          wcnt_inc;
    logic                   issuing;
    logic                   retire;
    logic                   final_wr;

    logic [7:0]    lane_in   [LANES];
    logic [LANES-1:0] lane_vld;
    logic [TW-1:0] lane_tag  [LANES];
    logic [7:0]    lane_out  [LANES];

    assign issuing  = (state_q == ST_ISSUE);
    assign retire   = lane_vld[0];
    assign wcnt_inc = wcnt_q + 1'b1;
    assign final_wr = retire && (wcnt_inc == WLAST);

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        assign lane_in[j] = hold_q[AES_STATE_W-1 - 8*(int'(icnt_q)*LANES + j) -: 8];

        sbox_subbytes_seq_lane #(
            .PIPE (PIPE),
            .TW   (TW)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_vld   (issuing),
            .in_tag   (icnt_q),
            .in_byte  (lane_in[j]),
            .inv      (inv_q),
            .out_vld  (lane_vld[j]),
            .out_tag  (lane_tag[j]),
            .out_byte (lane_out[j])
        );
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (in_valid)            state_d = ST_ISSUE;
            ST_ISSUE: if (icnt_q == TLAST)     state_d = ST_DRAIN;
            ST_DRAIN: if (final_wr)            state_d = ST_DONE;
            ST_DONE:  if (out_ready)           state_d = ST_IDLE;
            default:                           state_d = ST_IDLE;
        endcase
    end

    // FSM outputs, all decoded straight from the state register.
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        busy      = (state_q != ST_IDLE);
    end

    // Input capture, issue/write counters and result assembly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q   <= '0;
            inv_q    <= SBOX_FWD;
            icnt_q   <= '0;
            wcnt_q   <= '0;
            result_q <= '0;
        end else begin
            if (state_q == ST_IDLE && in_valid) begin
                hold_q <= state_in;
                inv_q  <= inv_in;
                icnt_q <= '0;
                wcnt_q <= '0;
            end
            if (issuing) begin
                icnt_q <= (icnt_q == TLAST) ? '0 : icnt_q + 1'b1;
            end
            if (retire) begin
                wcnt_q <= wcnt_inc;
            end
            for (int j = 0; j < LANES; j++) begin
                if (lane_vld[j]) begin
                    result_q[AES_STATE_W-1 - 8*(int'(lane_tag[j])*LANES + j) -: 8] <= lane_out[j];
                end
            end
        end
    end

    assign state_out = result_q;

endmodule

// File: doc/sbox_subbytes_seq.md
Name: sbox_subbytes_seq

Overview:
- Byte-serial SubBytes/InvSubBytes sequencer for one 128-bit AES state.
- Time-multiplexes a configurable number of S-box lanes over the 16 state bytes. Each lane is a Canright compact S-box (GF(2^8) inversion built on the GF(2^4)/GF(2^2) tower inverter) followed by pipeline registers.
- Sits between the round controller and ShiftRows, with a valid/ready handshake on each side.

Parameters:
- LANES, 4, S-box instances working in parallel. Legal values: 1, 2, 4, 8, 16. ISSUES = 16/LANES.
- PIPE, 1, register stages per lane after the combinational S-box. Range 1..4.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  state_in and inv_in are valid
- in_ready  out  1  block can accept a new state
- state_in  in  128  input state; byte i = state_in[127-8i -: 8] (FIPS-197 byte order)
- inv_in  in  1  0 = forward S-box, 1 = inverse S-box; applies to the whole transaction
- out_valid  out  1  state_out holds the substituted state
- out_ready  in  1  downstream accepts state_out
- state_out  out  128  substituted state, same byte order as state_in
- busy  out  1  high in any state other than IDLE

Behaviour:
- States: IDLE, ISSUE, DRAIN, DONE.
- Reset (rst_n low, asynchronous):
  - state=IDLE; issue counter and write counter cleared.
  - Lane pipeline valid bits cleared; out_valid=0, busy=0, state_out=0.
  - in_ready=1 (combinational from IDLE). in_valid is ignored while rst_n is low.
  - Reset mid-transaction aborts it with no output. Stale pipeline data is never written.
- IDLE: in_ready=1. On in_valid&in_ready:
  - Latch state_in and inv_in into an input holding register.
  - Go to ISSUE with issue counter = 0.
- ISSUE:
  - On cycle k (k = 0..ISSUES-1), lane j receives byte k*LANES+j. The group is tagged with k and inserted into the lane pipeline.
  - The issue counter increments every cycle. After group ISSUES-1, go to DRAIN.
  - There are no stalls inside ISSUE. Backpressure exists only in DONE.
- DRAIN:
  - A group leaving the last pipe stage writes byte (tag*LANES+j) of the result register from lane j.
  - The write counter increments per group. When the final group is written, go to DONE.
  - Groups retire during ISSUE as well once PIPE cycles have elapsed.
- DONE:
  - out_valid=1. state_out is held stable, with every bit frozen, until out_ready.
  - On out_valid&out_ready, go to IDLE; out_valid falls on the next edge.
  - in_ready is 0 in DONE. There is no overlap between transactions, so at least one idle cycle separates them.
- Latency: out_valid rises exactly ISSUES+PIPE edges after the accepting edge. Examples: LANES=4,PIPE=1 gives 5; LANES=16,PIPE=1 gives 2; LANES=1,PIPE=4 gives 20.
- Throughput: one state per ISSUES+PIPE+2 cycles when out_ready is held high.
- Width rules:
  - Issue counter and tag: clog2(ISSUES) bits, minimum 1.
  - Write counter: clog2(ISSUES)+1 bits, so the terminal compare needs no wrap. The issue counter wraps to 0 on leaving ISSUE.
- inv_in is latched once per transaction. Changes on inv_in after acceptance have no effect.
- Changes on state_in outside the accept edge have no effect.
- in_valid held high in DONE is not accepted until the block returns to IDLE.
- out_ready asserted while out_valid=0 is ignored.

Decomposition:
- Shared header aes_sbox_defs.vh holds:
  - AES_STATE_W=128, AES_BYTES=16
  - S-box direction encodings SBOX_FWD=0, SBOX_INV=1
  - FSM state encodings (2-bit: IDLE=0, ISSUE=1, DRAIN=2, DONE=3)
- One sub-module, sbox_lane:
  - Contains the combinational Canright S-box with direction input, built from the existing GF tower modules, plus PIPE data/tag/valid registers.
  - Parameterised by PIPE, reset by rst_n.
  - Instantiated LANES times by a generate loop.

Test Plan:
- All-zero state, inv_in=0, LANES=4, PIPE=1, out_ready=1 -> state_out = 16 bytes of 0x63; out_valid rises 5 edges after accept and stays high for 1 cycle.
- FIPS-197 vector, state_in=193de3bea0f4e22b9ac68d2ae9f84808, inv_in=0 -> state_out=d42711aee0bf98f1b8b45de51e415230.
  - Repeat with inv_in=1 on the output -> original input recovered.
  - Sweep LANES in {1,2,4,8,16} and PIPE in {1,4}; latency must equal 16/LANES+PIPE.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, state_out unchanged, in_ready=0.
  - Then out_ready=1 -> exactly one handshake and a return to IDLE.
- Reset mid-ISSUE (LANES=1, assert rst_n low on cycle 7 of ISSUE) -> out_valid=0 and busy=0 immediately.
  - A fresh transaction after release with state_in=0x53 repeated -> all bytes 0xED; no byte from the aborted state appears.
- Input stability: change state_in and inv_in every cycle after acceptance -> result reflects only the accepted values. Also check that in_valid held high during DONE is not accepted.
- Exhaustive byte coverage: 16 transactions whose states together contain each value 0x00..0xFF once per byte position, fwd and inv -> every byte matches a reference S-box table.
